spinner_multi: RTL and testbench



---
 rtl/spinner_multi_if.sv | 27 ++
 rtl/spinner_multi.sv | 198 +++++++++++++++++++
 tb/tb_spinner_multi.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/spinner_multi_if.sv
// Bundled control/status signals for the multi-channel spinner.
// Master drives buttons, strobe and spinner samples; slave returns angles and quadrature.
interface spinner_multi_if #(
  parameter int NCH   = 2,
  parameter int WIDTH = 4
);
  logic                   strobe;
  logic [NCH-1:0]         minus;
  logic [NCH-1:0]         plus;
  logic [NCH-1:0]         fast;
  logic [9*NCH-1:0]       spin_in;
  logic [NCH-1:0]         mode_clamp;
  logic [WIDTH*NCH-1:0]   spin_out;
  logic [NCH-1:0]         qa;
  logic [NCH-1:0]         qb;
  logic [NCH-1:0]         q_busy;

  modport master (
    output strobe, minus, plus, fast, spin_in, mode_clamp,
    input  spin_out, qa, qb, q_busy
  );

  modport slave (
    input  strobe, minus, plus, fast, spin_in, mode_clamp,
    output spin_out, qa, qb, q_busy
  );
endinterface

// File: rtl/spinner_multi.sv
// Multi-channel spinner: button/delta driven position per channel with wrap or
// clamp, plus a rate-limited quadrature encoder replaying each applied change.
module spinner_multi_ch #(
  parameter int WIDTH    = 4,
  parameter int SLOW_DIV = 8,
  parameter int FAST_DIV = 2,
  parameter int SP_SHIFT = 2,
  parameter int QDIV     = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_strb_rise,
  input  logic             i_minus,
  input  logic             i_plus,
  input  logic             i_fast,
  input  logic [8:0]       i_spin,
  input  logic             i_clamp,
  output logic [WIDTH-1:0] o_angle,
  output logic             o_qa,
  output logic             o_qb,
  output logic             o_busy
);
  localparam int PW     = WIDTH + SP_SHIFT;
  localparam int EW     = PW + 10;
  localparam int MAXDIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW     = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;
  localparam int TW     = (QDIV > 1) ? $clog2(QDIV) : 1;

  localparam logic [CW-1:0]        SLOW_RL = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0]        FAST_RL = CW'(FAST_DIV - 1);
  localparam logic [TW-1:0]        T_RL    = TW'(QDIV - 1);
  localparam logic signed [EW-1:0] ZERO    = '0;
  localparam logic signed [EW-1:0] ONE     = EW'(1);
  localparam logic signed [EW-1:0] STEP    = EW'(2 ** SP_SHIFT);
  localparam logic signed [EW-1:0] POS_MAX = EW'((2 ** PW) - 1);
  localparam logic signed [EW-1:0] P127    = EW'(127);

  logic [PW-1:0]       r_pos;
  logic [CW-1:0]       r_cnt;
  logic                r_act;
  logic                r_dir;
  logic                r_tog;
  logic signed [7:0]   r_pend;
  logic [1:0]          r_gray;
  logic [TW-1:0]       r_timer;
  logic                r_busy;

  logic                w_act;
  logic                w_chg;
  logic [CW-1:0]       w_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_step;
  logic                w_tog;
  logic signed [EW-1:0] w_pos_x;
  logic signed [EW-1:0] w_step_v;
  logic signed [EW-1:0] w_spin_v;
  logic signed [EW-1:0] w_sum;
  logic signed [EW-1:0] w_lim;
  logic signed [EW-1:0] w_app;
  logic signed [EW-1:0] w_d;
  logic                w_emit;
  logic signed [EW-1:0] w_emit_v;
  logic signed [EW-1:0] w_pend_x;
  logic signed [EW-1:0] w_pacc;
  logic signed [EW-1:0] w_pnext;
  logic [1:0]          w_gray_nxt;
  logic [TW-1:0]       w_timer_nxt;

  always_comb begin
    w_act = i_minus ^ i_plus;
    // a direction flip restarts the rate divider so the new direction steps at once
    w_chg = w_act & r_act & (r_dir != i_plus);
    w_cnt = w_chg ? '0 : r_cnt;
    w_step = i_strb_rise & w_act & (w_cnt == '0);

    w_cnt_nxt = w_cnt;
    if (!w_act)
      w_cnt_nxt = '0;
    else if (i_strb_rise)
      w_cnt_nxt = (w_cnt == '0) ? (i_fast ? FAST_RL : SLOW_RL) : w_cnt - 1'b1;

    w_tog    = i_spin[8] ^ r_tog;
    w_pos_x  = {{(EW-PW){1'b0}}, r_pos};
    w_step_v = w_step ? (i_plus ? STEP : -STEP) : ZERO;
    w_spin_v = w_tog ? {{(EW-8){i_spin[7]}}, i_spin[7:0]} : ZERO;
    w_sum    = w_pos_x + w_step_v + w_spin_v;

    w_lim = w_sum;
    if (w_sum < ZERO)         w_lim = ZERO;
    else if (w_sum > POS_MAX) w_lim = POS_MAX;
    w_app = i_clamp ? w_lim : w_sum;

    // unwrapped output delta keeps the encoder moving the same way across a wrap
    w_d = (w_app >>> SP_SHIFT) - (w_pos_x >>> SP_SHIFT);

    w_emit   = (r_timer == '0) && (r_pend != 8'sd0);
    w_emit_v = w_emit ? (r_pend[7] ? -ONE : ONE) : ZERO;
    w_pend_x = {{(EW-8){r_pend[7]}}, r_pend};
    w_pacc   = w_pend_x - w_emit_v + w_d;
    w_pnext  = w_pacc;
    if (w_pacc > P127)       w_pnext = P127;
    else if (w_pacc < -P127) w_pnext = -P127;

    w_gray_nxt = r_gray;
    if (w_emit)
      w_gray_nxt = r_pend[7] ? {~r_gray[0], r_gray[1]} : {r_gray[0], ~r_gray[1]};

    w_timer_nxt = '0;
    if (w_emit)               w_timer_nxt = T_RL;
    else if (r_timer != '0)   w_timer_nxt = r_timer - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pos   <= '0;
      r_cnt   <= '0;
      r_act   <= 1'b0;
      r_dir   <= 1'b0;
      r_tog   <= i_spin[8];
      r_pend  <= '0;
      r_gray  <= 2'b00;
      r_timer <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_pos   <= w_app[PW-1:0];
      r_cnt   <= w_cnt_nxt;
      r_act   <= w_act;
      if (w_act) r_dir <= i_plus;
      r_tog   <= i_spin[8];
      r_pend  <= w_pnext[7:0];
      r_gray  <= w_gray_nxt;
      r_timer <= w_timer_nxt;
      r_busy  <= (w_pnext != ZERO);
    end
  end

  assign o_angle = r_pos[PW-1 -: WIDTH];
  assign o_qa    = r_gray[1];
  assign o_qb    = r_gray[0];
  assign o_busy  = r_busy;
endmodule

module spinner_multi #(
  parameter int NCH      = 2,
  parameter int WIDTH    = 4,
  parameter int SLOW_DIV = 8,
  parameter int FAST_DIV = 2,
  parameter int SP_SHIFT = 2,
  parameter int QDIV     = 64
) (
  input  logic            clk,
  input  logic            reset,
  spinner_multi_if.slave  bus
);
  logic                        r_strb;
  logic                        w_rise;
  logic [NCH-1:0][WIDTH-1:0]   w_angle;
  logic [NCH-1:0]              w_qa;
  logic [NCH-1:0]              w_qb;
  logic [NCH-1:0]              w_busy;

  // tracks strobe in and out of reset, so a strobe high at release is not an edge
  always_ff @(posedge clk) begin
    r_strb <= bus.strobe;
  end

  assign w_rise = bus.strobe & ~r_strb;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      spinner_multi_ch #(
        .WIDTH    (WIDTH),
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV),
        .SP_SHIFT (SP_SHIFT),
        .QDIV     (QDIV)
      ) u_ch (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_strb_rise (w_rise),
        .i_minus     (bus.minus[g]),
        .i_plus      (bus.plus[g]),
        .i_fast      (bus.fast[g]),
        .i_spin      (bus.spin_in[9*g +: 9]),
        .i_clamp     (bus.mode_clamp[g]),
        .o_angle     (w_angle[g]),
        .o_qa        (w_qa[g]),
        .o_qb        (w_qb[g]),
        .o_busy      (w_busy[g])
      );
    end
  endgenerate

  assign bus.spin_out = w_angle;
  assign bus.qa       = w_qa;
  assign bus.qb       = w_qb;
  assign bus.q_busy   = w_busy;
endmodule

// File: tb/tb_spinner_multi.sv
// Directed bench for spinner_multi: table of button/spinner vectors plus
// hand sequences for reset toggle masking, quadrature pacing and same-cycle merge.
module tb_spinner_multi;
  localparam int NCH   = 2;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spinner_multi_if #(.NCH(NCH), .WIDTH(WIDTH)) bif();

  spinner_multi #(
    .NCH(NCH), .WIDTH(WIDTH), .SLOW_DIV(8), .FAST_DIV(2), .SP_SHIFT(2), .QDIV(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic [1:0] minus;
    logic [1:0] plus;
    logic [1:0] fast;
    logic [1:0] clamp;
    int         nstr;
    int         sch;
    logic [7:0] delta;
    int         e0;
    int         e1;
  } vec_t;

  vec_t tbl [17];
  int n_chk = 0;
  int n_err = 0;
  logic [NCH-1:0] tog;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      bif.strobe = 1'b1;
      tick(1);
      bif.strobe = 1'b0;
      tick(1);
    end
  endtask

  task automatic spin(input int ch, input logic [7:0] d);
    tog[ch] = ~tog[ch];
    bif.spin_in[9*ch +: 9] = {tog[ch], d};
  endtask

  function automatic int out(input int ch);
    logic [WIDTH-1:0] v;
    v = bif.spin_out[WIDTH*ch +: WIDTH];
    return int'(v);
  endfunction

  function automatic int qab(input int ch);
    return int'({bif.qa[ch], bif.qb[ch]});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int w;
    int eq;

    //          minus  plus   fast   clamp  nstr sch delta   e0  e1
    tbl[0]  = '{2'b00, 2'b01, 2'b00, 2'b00, 17, -1, 8'h00,  3,  0};
    tbl[1]  = '{2'b00, 2'b01, 2'b01, 2'b00,  1, -1, 8'h00,  4,  0};
    tbl[2]  = '{2'b00, 2'b01, 2'b01, 2'b00,  5, -1, 8'h00,  7,  0};
    tbl[3]  = '{2'b10, 2'b00, 2'b00, 2'b00,  1, -1, 8'h00,  7, 15};
    tbl[4]  = '{2'b00, 2'b10, 2'b00, 2'b00,  1, -1, 8'h00,  7,  0};
    tbl[5]  = '{2'b10, 2'b00, 2'b00, 2'b00,  1, -1, 8'h00,  7, 15};
    tbl[6]  = '{2'b00, 2'b10, 2'b00, 2'b10,  1, -1, 8'h00,  7, 15};
    tbl[7]  = '{2'b01, 2'b01, 2'b00, 2'b10,  3, -1, 8'h00,  7, 15};
    tbl[8]  = '{2'b00, 2'b00, 2'b00, 2'b10,  0,  1, 8'h80,  7,  0};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 2'b10,  0,  1, 8'h06,  7,  1};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b10,  0,  1, 8'h02,  7,  2};
    tbl[11] = '{2'b00, 2'b00, 2'b00, 2'b10,  0,  1, 8'h80,  7,  0};
    tbl[12] = '{2'b00, 2'b00, 2'b00, 2'b10,  0,  0, 8'hFF,  6,  0};
    tbl[13] = '{2'b00, 2'b00, 2'b00, 2'b10,  0,  0, 8'h7F,  6,  0};
    tbl[14] = '{2'b00, 2'b00, 2'b00, 2'b11,  0,  0, 8'h7F, 15,  0};
    tbl[15] = '{2'b00, 2'b00, 2'b00, 2'b10,  0, -1, 8'h00, 15,  0};
    tbl[16] = '{2'b00, 2'b01, 2'b00, 2'b10,  1, -1, 8'h00,  0,  0};

    reset = 1'b1;
    tog = '0;
    bif.strobe = 1'b0;
    bif.minus = '0;
    bif.plus = '0;
    bif.fast = '0;
    bif.mode_clamp = '0;
    bif.spin_in = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_spin_out", int'(bif.spin_out), 0);
    chk("rst_qa", int'(bif.qa), 0);
    chk("rst_qb", int'(bif.qb), 0);
    chk("rst_busy", int'(bif.q_busy), 0);

    for (int i = 0; i < 17; i++) begin
      bif.minus = tbl[i].minus;
      bif.plus = tbl[i].plus;
      bif.fast = tbl[i].fast;
      bif.mode_clamp = tbl[i].clamp;
      tick(1);
      pulse(tbl[i].nstr);
      if (tbl[i].sch >= 0) begin
        spin(tbl[i].sch, tbl[i].delta);
        tick(1);
      end
      bif.minus = '0;
      bif.plus = '0;
      tick(2);
      chk($sformatf("vec%0d_ch0", i), out(0), tbl[i].e0);
      chk($sformatf("vec%0d_ch1", i), out(1), tbl[i].e1);
    end

    // toggle bits high across reset must not count as samples
    bif.mode_clamp = '0;
    bif.fast = '0;
    reset = 1'b1;
    tog = 2'b11;
    bif.spin_in = {1'b1, 8'h00, 1'b1, 8'h00};
    tick(2);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (bif.spin_out != '0) bad++;
    end
    chk("tog_hold_bad_cycles", bad, 0);
    chk("tog_hold_q", qab(0), 0);
    chk("tog_hold_busy", int'(bif.q_busy), 0);

    // +12 counts = +3 output units: three forward edges, 4 clocks apart
    spin(0, 8'd12);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      eq = (k < 2) ? 0 : (k < 6) ? 1 : (k < 10) ? 3 : 2;
      chk($sformatf("quad_fwd_k%0d", k), qab(0), eq);
      chk($sformatf("quad_busy_k%0d", k), int'(bif.q_busy[0]), (k < 10) ? 1 : 0);
      if (k == 1) chk("quad_out", out(0), 3);
    end

    spin(0, 8'hFC);
    tick(1);
    chk("quad_rev_busy", int'(bif.q_busy[0]), 1);
    w = 0;
    while (bif.q_busy[0] && w < 40) begin
      tick(1);
      w++;
    end
    chk("quad_rev_timeout", int'(w >= 40), 0);
    chk("quad_rev_q", qab(0), 3);
    chk("quad_rev_out", out(0), 2);

    // step and spinner delta landing on the same clock
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    bif.mode_clamp = 2'b10;
    bif.minus = 2'b11;
    tick(1);
    bif.strobe = 1'b1;
    spin(0, 8'd8);
    tick(1);
    bif.strobe = 1'b0;
    chk("sim_out0", out(0), 1);
    chk("sim_out1", out(1), 0);
    chk("sim_busy0", int'(bif.q_busy[0]), 1);
    chk("sim_busy1", int'(bif.q_busy[1]), 0);
    bif.minus = '0;
    w = 0;
    while (bif.q_busy[0] && w < 40) begin
      tick(1);
      w++;
    end
    chk("sim_timeout", int'(w >= 40), 0);
    chk("sim_q0", qab(0), 1);
    chk("sim_q1", qab(1), 0);
    chk("sim_out0_final", out(0), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
